// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulo counter.
// The master drives the step/load controls; the slave (counter) returns count and flags.
interface updown_mod_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] counter;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  counter, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output counter, tc, wrap
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Purpose: parametrised up/down modulo counter with clamped parallel load, tc and wrap flags.
// Latency: one clock from en/load to new count; tc combinational, wrap one clock after tc.
// Backpressure: none, a step or load is accepted every cycle. SATURATE_EN: hold at bound instead of wrapping.
module updown_mod_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 1 << WIDTH,
    parameter int RST_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_mod_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

    generate
        if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH) || RST_VAL >= MODULUS || RST_VAL < 0) begin : g_bad_params
            $error("updown_mod_counter: illegal WIDTH/MODULUS/RST_VAL combination");
        end
    endgenerate

    logic             at_top;
    logic             at_bot;
    logic             at_bound;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;

    assign at_top   = (bus.counter == MAX_VAL);
    assign at_bot   = (bus.counter == '0);
    assign at_bound = bus.up_dn ? at_top : at_bot;

    assign bus.tc = bus.en & ~bus.load & at_bound;

    // Only the bound cases leave the plain +/-1 path, so no value above MAX_VAL is ever formed.
    always_comb begin
        cnt_nxt  = bus.counter;
        wrap_nxt = 1'b0;
        if (bus.load) begin
            cnt_nxt = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.en) begin
            if (at_bound) begin
`ifdef SATURATE_EN
                cnt_nxt = bus.counter;
`else
                cnt_nxt  = bus.up_dn ? '0 : MAX_VAL;
                wrap_nxt = 1'b1;
`endif
            end else if (bus.up_dn) begin
                cnt_nxt = bus.counter + 1'b1;
            end else begin
                cnt_nxt = bus.counter - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.counter <= RST_CNT;
            bus.wrap    <= 1'b0;
        end else begin
            bus.counter <= cnt_nxt;
            bus.wrap    <= wrap_nxt;
        end
    end

    a_in_range: assert property (@(posedge clk) disable iff (!rst) bus.counter <= MAX_VAL);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: MODULUS=8 and MODULUS=6 instances, directed vectors, queued expectations.
module tb_updown_mod_counter;

    logic clk;
    logic rst;

    updown_mod_counter_if #(.WIDTH(3)) bus8 ();
    updown_mod_counter_if #(.WIDTH(3)) bus6 ();

    updown_mod_counter #(.WIDTH(3), .MODULUS(8), .RST_VAL(0)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    updown_mod_counter #(.WIDTH(3), .MODULUS(6), .RST_VAL(0)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        int         sel;
        logic       tc;
        logic [2:0] cnt;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_vec  = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    // sel 0 drives the MODULUS=8 instance, sel 1 the MODULUS=6 one; the other is held idle.
    task automatic step(input int sel, input logic e, input logic up, input logic ld,
                        input logic [2:0] lv, input logic xtc, input logic [2:0] xc, input logic xw);
        exp_t x;
        @(negedge clk);
        bus8.en = 1'b0; bus8.load = 1'b0;
        bus6.en = 1'b0; bus6.load = 1'b0;
        if (sel == 0) begin
            bus8.en = e; bus8.up_dn = up; bus8.load = ld; bus8.load_val = lv;
        end else begin
            bus6.en = e; bus6.up_dn = up; bus6.load = ld; bus6.load_val = lv;
        end
        x.idx = n_vec; x.sel = sel; x.tc = xtc; x.cnt = xc; x.wrap = xw;
        exp_q.push_back(x);
        n_vec++;
    endtask

    task automatic idle();
        @(negedge clk);
        bus8.en = 1'b0; bus8.load = 1'b0;
        bus6.en = 1'b0; bus6.load = 1'b0;
    endtask

    // Monitor: tc is checked with inputs settled before the edge, counter/wrap just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tc", e.idx, int'(e.sel == 0 ? bus8.tc : bus6.tc), int'(e.tc));
                @(posedge clk);
                #1;
                check("counter", e.idx, int'(e.sel == 0 ? bus8.counter : bus6.counter), int'(e.cnt));
                check("wrap", e.idx, int'(e.sel == 0 ? bus8.wrap : bus6.wrap), int'(e.wrap));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus8.en = 1'b1; bus8.up_dn = 1'b0; bus8.load = 1'b0; bus8.load_val = 3'd0;
        bus6.en = 1'b0; bus6.up_dn = 1'b1; bus6.load = 1'b0; bus6.load_val = 3'd0;
        #3;
        check("rst_counter8", -1, int'(bus8.counter), 0);
        check("rst_wrap8", -1, int'(bus8.wrap), 0);
        check("rst_tc8", -1, int'(bus8.tc), 1);
        check("rst_counter6", -1, int'(bus6.counter), 0);
        @(posedge clk);
        #1;
        check("rst_hold8", -1, int'(bus8.counter), 0);
        @(negedge clk);
        rst = 1'b1;
        bus8.en = 1'b0;

        // MODULUS=8 down from 0
        step(0, 1, 0, 0, 0, 1, 7, 1);
        for (int c = 6; c >= 0; c--) step(0, 1, 0, 0, 0, 1'b0, 3'(c), 1'b0);
        step(0, 1, 0, 0, 0, 1, 7, 1);

        // MODULUS=6 up from 0
        for (int c = 1; c <= 5; c++) step(1, 1, 1, 0, 0, 1'b0, 3'(c), 1'b0);
        step(1, 1, 1, 0, 0, 1, 0, 1);

        // Loads: priority over en, clamp, no wrap at terminal count
        step(1, 0, 1, 1, 2, 0, 2, 0);
        step(1, 1, 1, 1, 4, 0, 4, 0);
        step(1, 1, 1, 1, 7, 0, 5, 0);
        step(1, 1, 1, 1, 5, 0, 5, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);

        // Hold, direction changes, toggling at 0
        step(1, 0, 0, 1, 3, 0, 3, 0);
        step(1, 0, 1, 0, 0, 0, 3, 0);
        step(1, 0, 0, 0, 0, 0, 3, 0);
        step(1, 0, 1, 0, 0, 0, 3, 0);
        step(1, 1, 1, 0, 0, 0, 4, 0);
        step(1, 1, 0, 0, 0, 0, 3, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 1, 0);

        // Bound behaviour on MODULUS=8
        step(0, 0, 0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
`ifdef SATURATE_EN
        step(0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0);
`else
        step(0, 1, 0, 0, 0, 1, 7, 1);
        step(0, 1, 0, 0, 0, 0, 6, 0);
`endif
        step(0, 0, 1, 1, 6, 0, 6, 0);
        step(0, 1, 1, 0, 0, 0, 7, 0);
`ifdef SATURATE_EN
        step(0, 1, 1, 0, 0, 1, 7, 0);
        step(0, 1, 1, 0, 0, 1, 7, 0);
`else
        step(0, 1, 1, 0, 0, 1, 0, 1);
        step(0, 1, 1, 0, 0, 0, 1, 0);
`endif

        // Asynchronous reset between edges at count 5
        step(0, 0, 0, 1, 5, 0, 5, 0);
        idle();
        #3 rst = 1'b0;
        #1;
        check("arst_counter", -1, int'(bus8.counter), 0);
        check("arst_wrap", -1, int'(bus8.wrap), 0);
        @(posedge clk);
        #1;
        check("arst_held", -1, int'(bus8.counter), 0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset while a wrap pulse is showing
`ifdef SATURATE_EN
        step(0, 1, 0, 0, 0, 1, 0, 0);
`else
        step(0, 1, 0, 0, 0, 1, 7, 1);
`endif
        idle();
        #3 rst = 1'b0;
        #1;
        check("arst_counter_w", -1, int'(bus8.counter), 0);
        check("arst_wrap_w", -1, int'(bus8.wrap), 0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 1, 0, 0, 0, 1, 0);

        idle();
        idle();
        check("queue_drained", -1, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
